sigmoid: RTL and testbench

Hard-sigmoid activation stage directly downstream of the `associate` neuron core. Forward pass: takes the signed weighted sum, returns the clamped piecewise-linear activation. Training (`en` high): keeps the forward input and accepts one error word for it. It then returns the error gated by the activation slope as feedback to `associate`'s backward channel.

---
 rtl/sigmoid.sv | 129 ++++++++++++
 tb/tb_sigmoid.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sigmoid.sv
// Hard-sigmoid activation stage: clamped piecewise-linear forward pass and
// slope-gated error feedback for training, one sample in flight at a time.
module sigmoid #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned FRAC  = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             arg_valid_i,
  output logic             arg_ready_o,
  input  logic [WIDTH-1:0] arg_data_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [WIDTH-1:0] res_data_o,
  input  logic             err_valid_i,
  output logic             err_ready_o,
  input  logic [WIDTH-1:0] err_data_i,
  output logic             fbk_valid_o,
  input  logic             fbk_ready_i,
  output logic [WIDTH-1:0] fbk_data_o
);

  localparam logic signed [WIDTH:0] One      = (WIDTH+1)'(2**FRAC);
  localparam logic signed [WIDTH:0] Half     = (WIDTH+1)'(2**(FRAC-1));
  localparam logic signed [WIDTH:0] Bound    = (WIDTH+1)'(2**(FRAC+1));
  localparam logic signed [WIDTH:0] NegBound = -Bound;
  localparam logic signed [WIDTH:0] Zero     = '0;

  typedef enum logic [1:0] {
    StIdle,
    StFwd,
    StWaitErr,
    StBwd
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] fbk_q, fbk_d;

  logic signed [WIDTH:0]   arg_ext;
  logic signed [WIDTH:0]   y_full;
  logic [WIDTH-1:0]        res_sat;
  logic signed [WIDTH:0]   x_ext;
  logic                    linear;
  logic signed [WIDTH-1:0] err_s;
  logic [WIDTH-1:0]        fbk_calc;

  // One extra bit keeps the shifted sum exact across the full input range.
  always_comb begin
    arg_ext = {arg_data_i[WIDTH-1], arg_data_i};
    y_full  = (arg_ext >>> 2) + Half;
    if (y_full > One) begin
      res_sat = One[WIDTH-1:0];
    end else if (y_full < Zero) begin
      res_sat = '0;
    end else begin
      res_sat = y_full[WIDTH-1:0];
    end
  end

  always_comb begin
    x_ext    = {x_q[WIDTH-1], x_q};
    linear   = (x_ext > NegBound) && (x_ext < Bound);
    err_s    = err_data_i;
    fbk_calc = linear ? WIDTH'(err_s >>> 2) : '0;
  end

  assign arg_ready_o = (state_q == StIdle);
  assign res_valid_o = (state_q == StFwd);
  assign err_ready_o = (state_q == StWaitErr);
  assign fbk_valid_o = (state_q == StBwd);
  assign res_data_o  = res_q;
  assign fbk_data_o  = fbk_q;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    mode_d  = mode_q;
    res_d   = res_q;
    fbk_d   = fbk_q;
    unique case (state_q)
      StIdle: begin
        if (arg_valid_i) begin
          x_d     = arg_data_i;
          mode_d  = en_i;
          res_d   = res_sat;
          state_d = StFwd;
        end
      end
      StFwd: begin
        if (res_ready_i) begin
          state_d = mode_q ? StWaitErr : StIdle;
        end
      end
      StWaitErr: begin
        if (err_valid_i) begin
          fbk_d   = fbk_calc;
          state_d = StBwd;
        end
      end
      StBwd: begin
        if (fbk_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      x_q     <= '0;
      mode_q  <= 1'b0;
      res_q   <= '0;
      fbk_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      mode_q  <= mode_d;
      res_q   <= res_d;
      fbk_q   <= fbk_d;
    end
  end

endmodule

// File: tb/tb_sigmoid.sv
// Directed and randomized bench for sigmoid against an integer reference model.
module tb_sigmoid;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        arg_valid = 1'b0;
  logic        arg_ready;
  logic [15:0] arg_data = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_data;
  logic        err_valid = 1'b0;
  logic        err_ready;
  logic [15:0] err_data = '0;
  logic        fbk_valid;
  logic        fbk_ready = 1'b0;
  logic [15:0] fbk_data;

  int n_checks = 0;
  int n_fail   = 0;

  sigmoid #(.WIDTH(16), .FRAC(8)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .arg_valid_i(arg_valid),
    .arg_ready_o(arg_ready),
    .arg_data_i (arg_data),
    .res_valid_o(res_valid),
    .res_ready_i(res_ready),
    .res_data_o (res_data),
    .err_valid_i(err_valid),
    .err_ready_o(err_ready),
    .err_data_i (err_data),
    .fbk_valid_o(fbk_valid),
    .fbk_ready_i(fbk_ready),
    .fbk_data_o (fbk_data)
  );

  always #5 clk = ~clk;

  // Floor division by 4, independent of any shift operator semantics.
  function automatic int floor4(input int v);
    return (v - (((v % 4) + 4) % 4)) / 4;
  endfunction

  function automatic logic [15:0] ref_res(input logic [15:0] x);
    int y;
    y = floor4(int'($signed(x))) + 128;
    if (y > 256) y = 256;
    if (y < 0) y = 0;
    return 16'(y);
  endfunction

  function automatic logic [15:0] ref_fbk(input logic [15:0] x, input logic [15:0] e);
    int xi;
    xi = int'($signed(x));
    if (xi > -512 && xi < 512) return 16'(floor4(int'($signed(e))));
    return 16'h0000;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_arg(input logic [15:0] x, input logic m);
    check("arg_ready_idle", 16'(arg_ready), 16'd1);
    arg_valid = 1'b1;
    arg_data  = x;
    en        = m;
    tick();
    arg_valid = 1'b0;
    en        = ~m;  // mode must have been latched at acceptance
  endtask

  task automatic take_res(input int hold, input logic [15:0] exp, input logic m);
    check("res_valid", 16'(res_valid), 16'd1);
    check("res_data", res_data, exp);
    for (int i = 0; i < hold; i++) begin
      arg_valid = 1'b1;
      arg_data  = 16'($urandom);
      err_valid = 1'b1;
      tick();
      check("res_valid_hold", 16'(res_valid), 16'd1);
      check("res_data_hold", res_data, exp);
      check("arg_ready_hold", 16'(arg_ready), 16'd0);
      check("err_ready_fwd", 16'(err_ready), 16'd0);
    end
    arg_valid = 1'b0;
    err_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("res_valid_done", 16'(res_valid), 16'd0);
    check("arg_ready_after_res", 16'(arg_ready), m ? 16'd0 : 16'd1);
    check("err_ready_after_res", 16'(err_ready), m ? 16'd1 : 16'd0);
  endtask

  task automatic send_err(input logic [15:0] e);
    check("err_ready", 16'(err_ready), 16'd1);
    check("arg_ready_wait", 16'(arg_ready), 16'd0);
    err_valid = 1'b1;
    err_data  = e;
    en        = ~en;
    tick();
    err_valid = 1'b0;
  endtask

  task automatic take_fbk(input int hold, input logic [15:0] exp);
    check("fbk_valid", 16'(fbk_valid), 16'd1);
    check("fbk_data", fbk_data, exp);
    for (int i = 0; i < hold; i++) begin
      arg_valid = 1'b1;
      err_valid = 1'b1;
      err_data  = 16'($urandom);
      tick();
      check("fbk_valid_hold", 16'(fbk_valid), 16'd1);
      check("fbk_data_hold", fbk_data, exp);
      check("arg_ready_bwd", 16'(arg_ready), 16'd0);
      check("err_ready_bwd", 16'(err_ready), 16'd0);
    end
    arg_valid = 1'b0;
    err_valid = 1'b0;
    fbk_ready = 1'b1;
    tick();
    fbk_ready = 1'b0;
    check("fbk_valid_done", 16'(fbk_valid), 16'd0);
    check("arg_ready_after_fbk", 16'(arg_ready), 16'd1);
  endtask

  task automatic sample(input logic [15:0] x, input logic m, input logic [15:0] e,
                        input int hres, input int hfbk);
    send_arg(x, m);
    take_res(hres, ref_res(x), m);
    if (m) begin
      send_err(e);
      take_fbk(hfbk, ref_fbk(x, e));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_arg_ready"}, 16'(arg_ready), 16'd1);
    check({tag, "_res_valid"}, 16'(res_valid), 16'd0);
    check({tag, "_err_ready"}, 16'(err_ready), 16'd0);
    check({tag, "_fbk_valid"}, 16'(fbk_valid), 16'd0);
    check({tag, "_res_data"}, res_data, 16'h0000);
    check({tag, "_fbk_data"}, fbk_data, 16'h0000);
  endtask

  task automatic pulse_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs(tag);
    tick();
    rst = 1'b0;
    tick();
  endtask

  logic [15:0] fwd_x [7] = '{16'h0000, 16'h0100, 16'hff00, 16'h0300,
                             16'hfd00, 16'h7fff, 16'h8000};
  logic [15:0] fwd_y [7] = '{16'h0080, 16'h00c0, 16'h0040, 16'h0100,
                             16'h0000, 16'h0100, 16'h0000};

  initial begin
    // Reset with no clock edge: outputs must settle at once.
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("por");
    tick();
    rst = 1'b0;
    tick();

    // Forward table, inference mode, with literal expectations.
    for (int i = 0; i < 7; i++) begin
      send_arg(fwd_x[i], 1'b0);
      take_res(0, fwd_y[i], 1'b0);
    end

    // Backward cases with literal expectations.
    send_arg(16'h0100, 1'b1); take_res(0, 16'h00c0, 1'b1);
    send_err(16'h0040);       take_fbk(0, 16'h0010);
    send_arg(16'h0100, 1'b1); take_res(0, 16'h00c0, 1'b1);
    send_err(16'hffff);       take_fbk(0, 16'hffff);
    send_arg(16'h0200, 1'b1); take_res(0, 16'h0100, 1'b1);
    send_err(16'h1234);       take_fbk(0, 16'h0000);
    send_arg(16'hfe01, 1'b1); take_res(0, 16'h0000, 1'b1);
    send_err(16'h0100);       take_fbk(0, 16'h0040);
    send_arg(16'hfe00, 1'b1); take_res(0, 16'h0000, 1'b1);
    send_err(16'h0100);       take_fbk(0, 16'h0000);

    // Backpressure on both output channels.
    sample(16'h0080, 1'b1, 16'hff00, 5, 5);

    // Reset while waiting for the error.
    send_arg(16'h0040, 1'b1);
    take_res(0, ref_res(16'h0040), 1'b1);
    pulse_reset("rst_wait");
    sample(16'h0000, 1'b0, 16'h0000, 0, 0);

    // Reset while feedback is pending.
    send_arg(16'h0040, 1'b1);
    take_res(0, ref_res(16'h0040), 1'b1);
    send_err(16'h0400);
    check("fbk_valid_pre_rst", 16'(fbk_valid), 16'd1);
    pulse_reset("rst_bwd");
    sample(16'h0000, 1'b0, 16'h0000, 0, 0);

    // Randomized samples, biased towards the linear region and its edges.
    for (int i = 0; i < 60; i++) begin
      logic [15:0] x;
      logic [15:0] e;
      if ($urandom_range(0, 2) == 0) x = 16'($urandom);
      else x = 16'($urandom_range(0, 2047) - 1024);
      e = 16'($urandom);
      sample(x, 1'($urandom), e, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
